// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: one byte per txValid/txReady handshake, sent as an 11-bit frame.
// Optional host-inhibit detection and retransmit when PS2_TX_INHIBIT_EN is defined.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2500,
  parameter int SETUP       = 250,
  parameter int IDLE_GAP    = 2500
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PS2_TX_INHIBIT_EN
  input  logic       ps2ClkIn,
`endif
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       txDone,
  output logic       ps2Clk,
  output logic       ps2Data
);

  localparam int MAXP = (HALF_PERIOD > IDLE_GAP) ? HALF_PERIOD : IDLE_GAP;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);
  // Data is loaded on this edge so it is visible from HIGH-phase cycle HALF_PERIOD-SETUP.
  localparam logic [CW-1:0] DAT_CNT  = CW'(HALF_PERIOD - SETUP - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HIGH = 3'd1;
  localparam logic [2:0] S_LOW  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [10:0]   r_frame;
  logic          r_clk;
  logic          r_data;
  logic          r_rdy;
  logic          r_done;

  logic w_inh;
  logic w_abort;
  logic w_accept;

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0] r_sync;
  logic [1:0] r_clkq;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= 2'b11;
      r_clkq <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ps2ClkIn};
      r_clkq <= {r_clkq[0], r_clk};
    end
  end

  assign w_inh = ~r_sync[1];
  // Only trust a low sample once our own clock has been high across the synchronizer delay.
  assign w_abort = w_inh && r_clk && (&r_clkq) &&
                   ((r_state == S_HIGH) || (r_state == S_LOW) || (r_state == S_GAP));
`else
  assign w_inh   = 1'b0;
  assign w_abort = 1'b0;
`endif

  assign w_accept = txValid && r_rdy && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
      r_rdy   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= S_HOLD;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_clk   <= 1'b1;
        r_data  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_rdy <= ~w_inh;
            if (w_accept) begin
              r_frame <= {1'b1, ~^txData, txData, 1'b0};
              r_state <= S_HIGH;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_rdy   <= 1'b0;
            end
          end
          S_HIGH: begin
            if (r_cnt == DAT_CNT) r_data <= r_frame[r_bit];
            if (r_cnt == HP_LAST) begin
              r_state <= S_LOW;
              r_cnt   <= '0;
              r_clk   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_LOW: begin
            if (r_cnt == HP_LAST) begin
              r_cnt <= '0;
              r_clk <= 1'b1;
              if (r_bit == 4'd10) begin
                r_state <= S_GAP;
                r_data  <= 1'b1;
              end else begin
                r_state <= S_HIGH;
                r_bit   <= r_bit + 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_rdy   <= ~w_inh;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            // Bus must stay released for IDLE_GAP cycles before the latched byte is resent.
            if (w_inh) begin
              r_cnt <= '0;
            end else if (r_cnt == GAP_LAST) begin
              r_state <= S_HIGH;
              r_cnt   <= '0;
              r_bit   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_clk   <= 1'b1;
            r_data  <= 1'b1;
            r_rdy   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txReady = r_rdy;
  assign txDone  = r_done;
  assign ps2Clk  = r_clk;
  assign ps2Data = r_data;

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Synthesizable PS/2 device-side (keyboard-emulating) transmitter.
- Serializes one scan-code byte per request into an 11-bit PS/2 frame and drives ps2Clk/ps2Data toward the receiving PS/2 decoder in the paddle controller.
- Used for on-FPGA loopback self-test and as a reusable stimulus source, in place of hand-coded bit-level task sequences.

Parameters:
- HALF_PERIOD, 2500: clk cycles per ps2Clk high phase and per low phase (50 us at 50 MHz).
- SETUP, 250: clk cycles ps2Data is stable before each ps2Clk falling edge; must satisfy 1 <= SETUP < HALF_PERIOD.
- IDLE_GAP, 2500: clk cycles of bus idle (both lines high) after the stop bit before the next frame may begin.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- txData  in  8  scan-code byte to send
- txValid  in  1  request; byte accepted when txValid && txReady
- txReady  out  1  high when able to accept a byte
- txDone  out  1  one-cycle pulse when IDLE_GAP after a frame completes
- ps2Clk  out  1  PS/2 clock line, idles high
- ps2Data  out  1  PS/2 data line, idles high

Behaviour:
- Reset: rst sampled low on a clk edge forces the following values on the next edge:
  - ps2Clk=1, ps2Data=1, txReady=1, txDone=0
  - state IDLE; bit index and counters cleared.
  - Reset mid-frame aborts the frame immediately, with no stop bit; the line returns to idle-high.
- Frame format: start 0, data bits 0..7 (LSB first), odd parity (parity = ~^txData), stop 1. Eleven bit slots.
- Bit slot timing, 2*HALF_PERIOD cycles per slot:
  - HIGH phase: ps2Clk=1 for HALF_PERIOD cycles.
  - ps2Data updates to the slot's bit at HIGH-phase cycle (HALF_PERIOD-SETUP).
  - LOW phase: ps2Clk=0 for HALF_PERIOD cycles; ps2Data stays constant throughout.
  - The receiver samples on the falling edge.
- State machine:
  - IDLE: txReady=1. On accept, latch txData and compute parity → HIGH, bit index=0, counter=0. txReady drops the cycle after acceptance.
  - HIGH: count to HALF_PERIOD-1, then → LOW.
  - LOW: count to HALF_PERIOD-1. If bit index=10 → GAP; else increment bit index → HIGH.
  - GAP: ps2Clk=1, ps2Data=1 for IDLE_GAP cycles, then pulse txDone for one cycle → IDLE.
- Frame latency: acceptance to txDone = 22*HALF_PERIOD + IDLE_GAP cycles (±1 for the registered transition); the bench checks the exact value.
- Registered outputs only; ps2Clk and ps2Data never glitch.
- txValid asserted while not ready: held off. txData must remain stable until accepted. No byte is lost or duplicated.
- Back-to-back: txValid held high is accepted in the cycle txReady returns, so frames are separated by exactly IDLE_GAP idle cycles.
- txData changes after acceptance: no effect on the frame in flight.
- Counter widths sized by $clog2 of the largest parameter.

Optional Feature:
- Macro PS2_TX_INHIBIT_EN.
- Defined: adds input ps2ClkIn (1 bit, synchronized through two flops internally) representing host inhibit (host pulls the clock low).
  - In IDLE, while ps2ClkIn is low: txReady=0 and no frame starts.
  - During HIGH, LOW, or GAP, if ps2ClkIn is low while this block drives ps2Clk=1: abort the frame; drive ps2Clk=1 and ps2Data=1; wait until ps2ClkIn has been high for IDLE_GAP cycles; then retransmit the same latched byte from the start bit.
  - No txDone is generated for the aborted attempt.
- Undefined: no ps2ClkIn port; inhibit is never detected.

Test Plan:
- Use HALF_PERIOD=4, SETUP=1, IDLE_GAP=8 in all scenarios.
- Reset: hold rst=0 for 3 cycles → ps2Clk=1, ps2Data=1, txReady=1, txDone=0. Assert rst=0 mid-frame (bit 5) → lines high on the next edge, txReady=1.
- Single byte 0x44: data sampled at the 11 ps2Clk falling edges = 0,0,0,1,0,0,0,1,0,1,1. txDone exactly 96 cycles after acceptance. Data changes only 1 cycle before each falling edge.
- Parity check: send 0x4B → parity bit 1; 0x1C → parity 0; 0x00 → parity 1; 0xFF → parity 1. Every frame carries an odd count of ones across data+parity.
- Back-to-back: txValid held with 0xF0 then 0x1B → 0xF0 frame, exactly 8 idle cycles, 0x1B frame. Two txDone pulses. txReady low during each frame. The paddle-controller PS/2 decoder, fed by this block, reports 0xF0 then 0x1B.
- Hold-off: change txData while txReady=0 → transmitted byte equals the value latched at acceptance.
- PS2_TX_INHIBIT_EN: pull ps2ClkIn low during bit 4 of 0x44 → lines go high. After release plus 8 cycles, the full 0x44 frame is resent. Only one txDone pulse for the byte.
